// File: rtl/dmem_write_buffer_if.sv
// CPU data port plus RAM req/ack bus seen by the posted-write buffer.
// The slave view belongs to the buffer; the master view drives CPU requests and RAM responses.
interface dmem_write_buffer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_write;
  logic              mem_write_enabled;
  logic              mem_read_enabled;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_stall;
  logic              buf_empty;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_ack;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  mem_addr, mem_data_write, mem_write_enabled, mem_read_enabled,
    input  ram_ack, ram_rdata,
    output mem_data_in, mem_stall, buf_empty,
    output ram_req, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output mem_addr, mem_data_write, mem_write_enabled, mem_read_enabled,
    output ram_ack, ram_rdata,
    input  mem_data_in, mem_stall, buf_empty,
    input  ram_req, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/dmem_write_buffer.sv
// Posted-write FIFO with youngest-match load forwarding, in front of a
// variable-latency single-port data RAM using a registered req/ack handshake.
module dmem_write_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input logic                clk,
  input logic                rst,
  dmem_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // IDLE | RAM free ; RD_BUSY | load miss outstanding ; WR_BUSY | head store being written
  localparam logic [1:0] IDLE = 2'd0, RD_BUSY = 2'd1, WR_BUSY = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];

  logic              rd_only, fwd_hit, load_miss, pop, push, rd_ack;
  logic [DATA_W-1:0] fwd_data;
  logic [PW-1:0]     idx;

  // Walk from oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (fifo_addr_q[idx] == bus.mem_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_data_q[idx];
      end
    end
  end

  assign rd_only   = bus.mem_read_enabled && !bus.mem_write_enabled;
  assign load_miss = rd_only && !fwd_hit;
  assign pop       = (state_q == WR_BUSY) && bus.ram_ack;
  assign rd_ack    = (state_q == RD_BUSY) && bus.ram_ack;
  assign push      = bus.mem_write_enabled && ((count_q != CW'(DEPTH)) || pop);

  always_comb begin
    if (bus.mem_write_enabled) bus.mem_stall = !push;
    else                       bus.mem_stall = load_miss && !rd_ack;
  end

  always_comb begin
    if (rd_only && fwd_hit)     bus.mem_data_in = fwd_data;
    else if (rd_only && rd_ack) bus.mem_data_in = bus.ram_rdata;
    else                        bus.mem_data_in = '0;
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (load_miss) begin
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = bus.mem_addr;
          state_d = RD_BUSY;
        end else if (count_q != '0) begin
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = fifo_addr_q[head_q];
          wdata_d = fifo_data_q[head_q];
          state_d = WR_BUSY;
        end
      end
      RD_BUSY, WR_BUSY: begin
        if (bus.ram_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Storage needs no reset: count_q alone decides which slots are valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_addr_q[tail_q] <= bus.mem_addr;
      fifo_data_q[tail_q] <= bus.mem_data_write;
    end
  end

  assign bus.ram_req   = req_q;
  assign bus.ram_we    = we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.buf_empty = (count_q == '0) && (state_q != WR_BUSY);
endmodule

// File: tb/tb_dmem_write_buffer.sv
// Bench for dmem_write_buffer: directed scenarios then random traffic, checked
// against a queue of pending stores and an architectural memory image.
module tb_dmem_write_buffer;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_write_buffer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  dmem_write_buffer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  logic [DW-1:0] arch_mem [logic [AW-1:0]];
  logic [DW-1:0] ram_mem  [logic [AW-1:0]];
  int            total = 0;
  int            bad = 0;
  int            wr_count = 0;
  int            rd_issue = 0;
  logic          hold = 1'b0;
  int            lat = 0;

  function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : '0;
  endfunction

  function automatic logic [DW-1:0] arch_rd(input logic [AW-1:0] a);
    return arch_mem.exists(a) ? arch_mem[a] : '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM responder: acks after lat extra cycles unless held; writes land one edge later.
  initial begin : ram_model
    logic          pend_w;
    logic [AW-1:0] pend_a;
    logic [DW-1:0] pend_d;
    int            wait_k;
    pend_w = 1'b0;
    pend_a = '0;
    pend_d = '0;
    wait_k = 0;
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pend_w) begin
        ram_mem[pend_a] = pend_d;
        wr_count++;
        pend_w = 1'b0;
      end
      if (!bus.ram_req) begin
        wait_k      = 0;
        bus.ram_ack = 1'b0;
      end else begin
        if (wait_k == 0 && !bus.ram_we) rd_issue++;
        if (!hold && wait_k >= lat) begin
          bus.ram_ack   = 1'b1;
          bus.ram_rdata = ram_rd(bus.ram_addr);
          if (bus.ram_we) begin
            pend_w = 1'b1;
            pend_a = bus.ram_addr;
            pend_d = bus.ram_wdata;
          end
        end else begin
          bus.ram_ack = 1'b0;
        end
        wait_k++;
      end
    end
  end

  task automatic do_cycle(input logic we, input logic re, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output logic stalled);
    logic          wr_done, rd_done, is_ld, hit, exp_stall;
    logic [DW-1:0] exp_data;
    ent_t          e;
    @(negedge clk);
    bus.mem_write_enabled = we;
    bus.mem_read_enabled  = re;
    bus.mem_addr          = a;
    bus.mem_data_write    = d;
    #1;
    wr_done = bus.ram_req && bus.ram_we && bus.ram_ack;
    rd_done = bus.ram_req && !bus.ram_we && bus.ram_ack;
    is_ld   = re && !we;
    hit     = 1'b0;
    foreach (mq[i]) if (mq[i].a == a) hit = 1'b1;
    if (we)         exp_stall = (mq.size() == DEPTH) && !wr_done;
    else if (is_ld) exp_stall = !hit && !rd_done;
    else            exp_stall = 1'b0;
    exp_data = (is_ld && !exp_stall) ? arch_rd(a) : '0;
    chk("stall", 32'(bus.mem_stall), 32'(exp_stall));
    chk("load_data", 32'(bus.mem_data_in), 32'(exp_data));
    chk("buf_empty", 32'(bus.buf_empty), 32'(mq.size() == 0));
    if (wr_done) begin
      chk("wr_pending", 32'(mq.size() > 0), 32'(1));
      if (mq.size() > 0) begin
        chk("wr_addr", 32'(bus.ram_addr), 32'(mq[0].a));
        chk("wr_data", 32'(bus.ram_wdata), 32'(mq[0].d));
        void'(mq.pop_front());
      end
    end
    if (rd_done && is_ld) chk("rd_addr", 32'(bus.ram_addr), 32'(a));
    if (we && !exp_stall) begin
      e.a = a;
      e.d = d;
      mq.push_back(e);
      arch_mem[a] = d;
    end
    stalled = bus.mem_stall;
  endtask

  task automatic run_op(input logic we, input logic re, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    logic st;
    int   n;
    n = 0;
    do begin
      do_cycle(we, re, a, d, st);
      n++;
    end while (st && n < 60);
    chk("op_timeout", 32'(st), 32'(0));
  endtask

  task automatic drain();
    logic st;
    int   n;
    n = 0;
    do begin
      do_cycle(1'b0, 1'b0, '0, '0, st);
      n++;
    end while (!bus.buf_empty && n < 200);
    chk("drain", 32'(bus.buf_empty), 32'(1));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic          st;
    int            base_wr, base_rd, op;
    logic [AW-1:0] ra;
    logic [DW-1:0] rdv;

    rst = 1'b1;
    bus.mem_addr = '0;
    bus.mem_data_write = '0;
    bus.mem_write_enabled = 1'b0;
    bus.mem_read_enabled = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req", 32'(bus.ram_req), 32'(0));
    chk("rst_we", 32'(bus.ram_we), 32'(0));
    chk("rst_addr", 32'(bus.ram_addr), 32'(0));
    chk("rst_wdata", 32'(bus.ram_wdata), 32'(0));
    chk("rst_empty", 32'(bus.buf_empty), 32'(1));
    chk("rst_stall", 32'(bus.mem_stall), 32'(0));
    chk("rst_data", 32'(bus.mem_data_in), 32'(0));

    // Forwarding from the head while it is being written
    hold = 1'b1;
    lat  = 0;
    do_cycle(1'b1, 1'b0, 16'd2, 16'd8, st);
    do_cycle(1'b0, 1'b1, 16'd2, 16'd0, st);
    chk("fwd_data", 32'(bus.mem_data_in), 32'd8);
    chk("fwd_stall", 32'(st), 32'(0));
    do_cycle(1'b0, 1'b1, 16'd2, 16'd0, st);
    chk("fwd_data2", 32'(bus.mem_data_in), 32'd8);
    chk("fwd_req", 32'(bus.ram_req), 32'(1));
    chk("fwd_we", 32'(bus.ram_we), 32'(1));
    chk("fwd_addr", 32'(bus.ram_addr), 32'd2);
    hold = 1'b0;
    drain();

    // Load miss with single-cycle RAM latency
    run_op(1'b1, 1'b0, 16'd0, 16'd5);
    drain();
    do_cycle(1'b0, 1'b1, 16'd0, 16'd0, st);
    chk("miss_stall0", 32'(st), 32'(1));
    do_cycle(1'b0, 1'b1, 16'd0, 16'd0, st);
    chk("miss_req", 32'(bus.ram_req), 32'(1));
    chk("miss_we", 32'(bus.ram_we), 32'(0));
    chk("miss_addr", 32'(bus.ram_addr), 32'd0);
    chk("miss_data", 32'(bus.mem_data_in), 32'd5);
    chk("miss_stall1", 32'(st), 32'(0));
    do_cycle(1'b0, 1'b0, 16'd0, 16'd0, st);
    chk("miss_req_drop", 32'(bus.ram_req), 32'(0));

    // Full FIFO: fifth store waits for the ack cycle
    hold = 1'b1;
    base_wr = wr_count;
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b1, 1'b0, AW'(10 + i), DW'(16'h100 + i), st);
      chk("full_acc", 32'(st), 32'(0));
    end
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b1, 1'b0, 16'd14, 16'h104, st);
      chk("full_stall", 32'(st), 32'(1));
    end
    hold = 1'b0;
    do_cycle(1'b1, 1'b0, 16'd14, 16'h104, st);
    chk("full_ack_accept", 32'(st), 32'(0));
    drain();
    chk("full_writes", 32'(wr_count - base_wr), 32'd5);
    chk("full_last", 32'(ram_rd(16'd14)), 32'h104);

    // Youngest matching entry wins
    base_wr = wr_count;
    do_cycle(1'b1, 1'b0, 16'd3, 16'd1, st);
    do_cycle(1'b1, 1'b0, 16'd3, 16'd7, st);
    do_cycle(1'b0, 1'b1, 16'd3, 16'd0, st);
    chk("young_data", 32'(bus.mem_data_in), 32'd7);
    chk("young_stall", 32'(st), 32'(0));
    drain();
    chk("young_ram", 32'(ram_rd(16'd3)), 32'd7);
    chk("young_writes", 32'(wr_count - base_wr), 32'd2);

    // Read and write together act as a store only
    base_rd = rd_issue;
    do_cycle(1'b1, 1'b1, 16'd4, 16'd9, st);
    chk("rdwr_data", 32'(bus.mem_data_in), 32'd0);
    chk("rdwr_stall", 32'(st), 32'(0));
    drain();
    chk("rdwr_noread", 32'(rd_issue - base_rd), 32'd0);
    chk("rdwr_ram", 32'(ram_rd(16'd4)), 32'd9);

    // Reset in the middle of a drain discards pending stores
    hold = 1'b1;
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, AW'(20 + i), DW'(16'hA0 + i), st);
    do_cycle(1'b0, 1'b0, 16'd0, 16'd0, st);
    chk("pre_rst_busy", 32'(bus.ram_req), 32'(1));
    base_wr = wr_count;
    @(negedge clk);
    rst = 1'b1;
    bus.mem_write_enabled = 1'b0;
    bus.mem_read_enabled = 1'b0;
    @(negedge clk);
    #1;
    chk("rst1_req", 32'(bus.ram_req), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst2_req", 32'(bus.ram_req), 32'(0));
    chk("rst2_empty", 32'(bus.buf_empty), 32'(1));
    chk("rst2_stall", 32'(bus.mem_stall), 32'(0));
    chk("rst2_data", 32'(bus.mem_data_in), 32'(0));
    mq.delete();
    arch_mem = ram_mem;
    hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      do_cycle(1'b0, 1'b0, 16'd0, 16'd0, st);
      chk("rst_no_req", 32'(bus.ram_req), 32'(0));
    end
    chk("rst_no_wr", 32'(wr_count - base_wr), 32'd0);

    // Random traffic over a small address window
    for (int k = 0; k < 300; k++) begin
      op  = $urandom_range(7, 0);
      ra  = AW'($urandom_range(7, 0));
      rdv = DW'($urandom);
      lat = $urandom_range(3, 0);
      if (op <= 2)      run_op(1'b1, 1'b0, ra, rdv);
      else if (op <= 5) run_op(1'b0, 1'b1, ra, '0);
      else if (op == 6) run_op(1'b1, 1'b1, ra, rdv);
      else              do_cycle(1'b0, 1'b0, ra, '0, st);
    end
    drain();
    foreach (arch_mem[k]) chk("final_mem", 32'(ram_rd(k)), 32'(arch_mem[k]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
